// File: rtl/store_narrow_unit_pkg.sv
// -----------------------------------------------------------------------------
// store_pkg
// Shared definitions for the store narrowing unit:
//   - access size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL)
//   - FSM state enum (ST_IDLE, ST_WRITE)
//   - size_to_count(): maps an access size to the number of bytes to write
//     (0 for the illegal encoding, which doubles as the legality test)
// -----------------------------------------------------------------------------
package store_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    // Byte count for an access size; the illegal size yields zero bytes.
    function automatic logic [2:0] size_to_count(input logic [1:0] size);
        logic [2:0] cnt;
        case (size)
            SZ_BYTE: cnt = 3'd1;
            SZ_HALF: cnt = 3'd2;
            SZ_WORD: cnt = 3'd4;
            SZ_ILL:  cnt = 3'd0;
            default: cnt = 3'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/store_narrow_unit_byte_lane_select.sv
// -----------------------------------------------------------------------------
// byte_lane_select
// Purely combinational byte-lane multiplexer: picks little-endian byte i_idx
// out of a 32-bit word.
// Ports:
//   i_word  [31:0]  source word, byte k is i_word[8k+7:8k]
//   i_idx   [1:0]   byte index
//   o_byte  [7:0]   selected byte
// -----------------------------------------------------------------------------
module byte_lane_select (
    input  logic [31:0] i_word,
    input  logic [1:0]  i_idx,
    output logic [7:0]  o_byte
);

    // Little-endian lane selection.
    always_comb begin
        o_byte = 8'h00;
        case (i_idx)
            2'd0:    o_byte = i_word[7:0];
            2'd1:    o_byte = i_word[15:8];
            2'd2:    o_byte = i_word[23:16];
            2'd3:    o_byte = i_word[31:24];
            default: o_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/store_narrow_unit.sv
// -----------------------------------------------------------------------------
// store_narrow_unit
// Serialises the low 1, 2 or 4 bytes of a 32-bit store into consecutive
// little-endian byte writes to a byte-wide memory port, one byte per accepted
// memory cycle. Addresses wrap modulo 2^ADDR_W.
//
// Optional feature: define STORE_ALIGN_CHECK_EN to reject misaligned halfword
// and word stores (err_o pulse, no writes). Without it misaligned stores are
// written bytewise from addr_i upward and only size 2'b11 is rejected.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-low reset
//   req_valid_i  store request valid
//   req_ready_o  high only in IDLE
//   addr_i       byte address of the first byte
//   data_i       register data
//   size_i       00 byte, 01 halfword, 10 word, 11 illegal
//   mem_we_o     byte write request
//   mem_addr_o   byte write address
//   mem_data_o   byte write data
//   mem_ready_i  memory accepts the current write this cycle
//   done_o       one-cycle pulse after the last byte is accepted
//   err_o        one-cycle pulse when a request is rejected
// -----------------------------------------------------------------------------
module store_narrow_unit
    import store_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    input  logic [1:0]        size_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_data_o,
    input  logic              mem_ready_i,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [31:0]       r_data;
    logic [31:0]       w_data_nxt;
    logic [1:0]        r_idx;
    logic [1:0]        w_idx_nxt;
    logic [1:0]        r_last;
    logic [1:0]        w_last_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_err;
    logic              w_err_nxt;

    logic              w_hs;
    logic [2:0]        w_cnt;
    logic              w_align_ok;
    logic              w_legal;
    logic [7:0]        w_lane;

    assign w_hs  = req_valid_i & req_ready_o;
    assign w_cnt = size_to_count(size_i);

    // Alignment qualification of the incoming request.
    always_comb begin
        w_align_ok = 1'b1;
`ifdef STORE_ALIGN_CHECK_EN
        if ((size_i == SZ_HALF) && (addr_i[0] != 1'b0)) begin
            w_align_ok = 1'b0;
        end else if ((size_i == SZ_WORD) && (addr_i[1:0] != 2'b00)) begin
            w_align_ok = 1'b0;
        end else begin
            w_align_ok = 1'b1;
        end
`else
        w_align_ok = 1'b1;
`endif
    end

    assign w_legal = (w_cnt != 3'd0) && w_align_ok;

    // Next-state and datapath-register logic for the IDLE/WRITE FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_addr_nxt = addr_i;
                    w_data_nxt = data_i;
                    w_idx_nxt  = 2'd0;
                    // Last index is count-1; a count of 4 wraps to index 3.
                    w_last_nxt = w_cnt[1:0] - 2'd1;
                    if (w_legal) begin
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // Without mem_ready_i every register holds, so outputs stay stable.
                if (mem_ready_i) begin
                    if (r_idx == r_last) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt  = r_idx + 2'd1;
                        w_addr_nxt = r_addr + ADDR_ONE;
                    end
                end else begin
                    w_state_nxt = ST_WRITE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_addr  <= {ADDR_W{1'b0}};
            r_data  <= 32'h0000_0000;
            r_idx   <= 2'd0;
            r_last  <= 2'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    byte_lane_select u_lane (
        .i_word (r_data),
        .i_idx  (r_idx),
        .o_byte (w_lane)
    );

    assign req_ready_o = (r_state == ST_IDLE);
    assign mem_we_o    = (r_state == ST_WRITE);
    assign mem_addr_o  = r_addr;
    assign mem_data_o  = w_lane;
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule
